sha256_k_stream: RTL and testbench

//  Streams SHA-256 round constants K[0..63] to a compression core, LANES constants per beat.
//  Run is launched by a start pulse; output uses a valid/ready handshake with full backpressure.

---
 rtl/sha256_pkg.sv | 28 ++
 rtl/sha256_k_stream_if.sv | 16 +
 rtl/sha256_k_lane.sv | 24 ++
 rtl/sha256_k_stream.sv | 148 ++++++++++++++
 tb/tb_sha256_k_stream.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/sha256_pkg.sv
// SHA-256 shared definitions: round/word sizes and the round-constant table.
// Used by the K streamer, the compression core and the message schedule.
package sha256_pkg;

    localparam int unsigned SHA256_ROUNDS = 64;
    localparam int unsigned SHA256_WORD   = 32;

    typedef enum logic [1:0] {StIdle, StRun, StDrain} k_state_e;

    localparam logic [31:0] K_TABLE [SHA256_ROUNDS] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1,
        32'h923f82a4, 32'hab1c5ed5, 32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174, 32'he49b69c1, 32'hefbe4786,
        32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147,
        32'h06ca6351, 32'h14292967, 32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85, 32'ha2bfe8a1, 32'ha81a664b,
        32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a,
        32'h5b9cca4f, 32'h682e6ff3, 32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] sha256_k(input logic [5:0] i);
        return K_TABLE[i];
    endfunction

endpackage

// File: rtl/sha256_k_stream_if.sv
// Round-constant beat stream: producer drives kt/kt_round/kt_last/kt_valid,
// consumer drives out_ready.
interface sha256_k_stream_if #(
    parameter int unsigned LANES = 1
);
    logic                   kt_valid;
    logic [32*LANES-1:0]    kt;
    logic [5:0]             kt_round;
    logic                   kt_last;
    logic                   out_ready;

    modport master (output kt_valid, output kt, output kt_round, output kt_last,
                    input out_ready);
    modport slave  (input kt_valid, input kt, input kt_round, input kt_last,
                    output out_ready);
endinterface

// File: rtl/sha256_k_lane.sv
// One K lane: 64x32 constant ROM with a registered, read-enabled output.
module sha256_k_lane
    import sha256_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        en,
    input  logic [5:0]  idx,
    output logic [31:0] k
);
    logic [31:0] k_q, k_d;

    always_comb begin
        k_d = k_q;
        if (en) k_d = sha256_k(idx);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) k_q <= '0;
        else          k_q <= k_d;
    end

    assign k = k_q;
endmodule

// File: rtl/sha256_k_stream.sv
// Streams SHA-256 round constants, LANES per beat, from START_ROUND to 63 with
// valid/ready backpressure and a PIPE-deep index-to-kt pipeline.
module sha256_k_stream
    import sha256_pkg::*;
#(
    parameter int unsigned LANES       = 1,
    parameter int unsigned START_ROUND = 0,
    parameter int unsigned PIPE        = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              abort,
    sha256_k_stream_if.master k_if,
    output logic              busy,
    output logic              done
);
    localparam int unsigned W       = SHA256_WORD * LANES;
    localparam logic [6:0]  LANES7  = 7'(LANES);
    localparam logic [6:0]  START7  = 7'(START_ROUND);
    localparam logic [6:0]  ROUNDS7 = 7'(SHA256_ROUNDS);

    if (!(LANES == 1 || LANES == 2 || LANES == 4)) begin : g_bad_lanes
        $error("sha256_k_stream: LANES must be 1, 2 or 4");
    end
    if (START_ROUND > 63 || ((SHA256_ROUNDS - START_ROUND) % LANES) != 0) begin : g_bad_start
        $error("sha256_k_stream: START_ROUND must leave a whole number of beats");
    end
    if (PIPE < 1 || PIPE > 3) begin : g_bad_pipe
        $error("sha256_k_stream: PIPE must be 1..3");
    end

    k_state_e              state_q, state_d;
    logic [6:0]            idx_q, idx_d;
    logic [6:0]            issue_idx, next_idx;
    logic                  en, accept, issue, issue_last;
    logic                  done_q, done_d;
    logic [PIPE-1:0]       vld_q, vld_d, last_q, last_d;
    logic [PIPE-1:0][5:0]  rnd_q, rnd_d;
    logic [W-1:0]          lane_k;

    // Global advance: the whole pipe stalls only when a presented beat is refused.
    assign en         = k_if.out_ready | ~k_if.kt_valid;
    assign accept     = (state_q == StIdle) & start & ~abort & en;
    assign issue      = accept | ((state_q == StRun) & en & ~abort);
    assign issue_idx  = (state_q == StIdle) ? START7 : idx_q;
    assign next_idx   = issue_idx + LANES7;
    assign issue_last = (next_idx == ROUNDS7);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        if (issue) idx_d = next_idx;
        if (abort) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle:  if (accept) state_d = issue_last ? StDrain : StRun;
                StRun:   if (issue && issue_last) state_d = StDrain;
                StDrain: begin
                    if (k_if.kt_valid && k_if.out_ready && k_if.kt_last) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Round/last tags only move with a valid beat so they stay aligned with kt.
    always_comb begin
        vld_d  = vld_q;
        last_d = last_q;
        rnd_d  = rnd_q;
        if (en) begin
            vld_d[0] = issue;
            if (issue) begin
                rnd_d[0]  = issue_idx[5:0];
                last_d[0] = issue_last;
            end
            for (int s = 1; s < int'(PIPE); s++) begin
                vld_d[s] = vld_q[s-1];
                if (vld_q[s-1]) begin
                    rnd_d[s]  = rnd_q[s-1];
                    last_d[s] = last_q[s-1];
                end
            end
        end
        if (abort) vld_d = '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            idx_q   <= '0;
            done_q  <= 1'b0;
            vld_q   <= '0;
            last_q  <= '0;
            rnd_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
            vld_q   <= vld_d;
            last_q  <= last_d;
            rnd_q   <= rnd_d;
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        sha256_k_lane u_lane (
            .clk     (clk),
            .reset_n (reset_n),
            .en      (issue),
            .idx     (issue_idx[5:0] + 6'(i)),
            .k       (lane_k[32*i +: 32])
        );
    end

    if (PIPE == 1) begin : g_nodata
        assign k_if.kt = lane_k;
    end else begin : g_data
        logic [PIPE-2:0][W-1:0] data_q, data_d;

        always_comb begin
            data_d = data_q;
            if (en && vld_q[0]) data_d[0] = lane_k;
            for (int s = 1; s < int'(PIPE) - 1; s++) begin
                if (en && vld_q[s]) data_d[s] = data_q[s-1];
            end
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) data_q <= '0;
            else          data_q <= data_d;
        end

        assign k_if.kt = data_q[PIPE-2];
    end

    assign k_if.kt_valid = vld_q[PIPE-1];
    assign k_if.kt_round = rnd_q[PIPE-1];
    assign k_if.kt_last  = last_q[PIPE-1];
    assign busy          = (state_q != StIdle);
    assign done          = done_q;
endmodule

// File: tb/tb_sha256_k_stream.sv
// Directed bench for sha256_k_stream: three configurations sharing one clock and reset.
module tb_sha256_k_stream;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n;
    logic a_start, a_abort, a_busy, a_done;
    logic b_start, b_abort, b_busy, b_done;
    logic c_start, c_abort, c_busy, c_done;

    sha256_k_stream_if #(.LANES(1)) a_if ();
    sha256_k_stream_if #(.LANES(4)) b_if ();
    sha256_k_stream_if #(.LANES(1)) c_if ();

    sha256_k_stream #(.LANES(1), .START_ROUND(0), .PIPE(1)) u_dut_a (
        .clk(clk), .reset_n(reset_n), .start(a_start), .abort(a_abort),
        .k_if(a_if), .busy(a_busy), .done(a_done)
    );
    sha256_k_stream #(.LANES(4), .START_ROUND(0), .PIPE(1)) u_dut_b (
        .clk(clk), .reset_n(reset_n), .start(b_start), .abort(b_abort),
        .k_if(b_if), .busy(b_busy), .done(b_done)
    );
    sha256_k_stream #(.LANES(1), .START_ROUND(3), .PIPE(3)) u_dut_c (
        .clk(clk), .reset_n(reset_n), .start(c_start), .abort(c_abort),
        .k_if(c_if), .busy(c_busy), .done(c_done)
    );

    logic [31:0] k_ref [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1,
        32'h923f82a4, 32'hab1c5ed5, 32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174, 32'he49b69c1, 32'hefbe4786,
        32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147,
        32'h06ca6351, 32'h14292967, 32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85, 32'ha2bfe8a1, 32'ha81a664b,
        32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a,
        32'h5b9cca4f, 32'h682e6ff3, 32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_a_round(input int r, input string tag);
        int found = 0;
        for (int cyc = 0; cyc < 100 && found == 0; cyc++) begin
            if (a_if.kt_valid === 1'b1 && a_if.kt_round === 6'(r)) found = 1;
            else tick();
        end
        chk(tag, found, 1);
    endtask

    task automatic drain_a(input int first, output int beats, output int errs, output int dones);
        int exp_r = first;
        beats = 0; errs = 0; dones = 0;
        for (int cyc = 0; cyc < 100; cyc++) begin
            if (a_if.kt_valid === 1'b1 && a_if.out_ready === 1'b1) begin
                if (exp_r > 63 || a_if.kt !== k_ref[exp_r] || a_if.kt_round !== 6'(exp_r)) errs++;
                exp_r++;
                beats++;
            end
            if (a_done === 1'b1) dones++;
            tick();
        end
    endtask

    task automatic drain_c(input int first, output int beats, output int errs, output int dones);
        int exp_r = first;
        beats = 0; errs = 0; dones = 0;
        for (int cyc = 0; cyc < 100; cyc++) begin
            if (c_if.kt_valid === 1'b1 && c_if.out_ready === 1'b1) begin
                if (exp_r > 63 || c_if.kt !== k_ref[exp_r] || c_if.kt_round !== 6'(exp_r)) errs++;
                exp_r++;
                beats++;
            end
            if (c_done === 1'b1) dones++;
            tick();
        end
    endtask

    initial begin
        int errs, beats, dones, found;
        reset_n = 1'b0;
        a_start = 0; a_abort = 0; b_start = 0; b_abort = 0; c_start = 0; c_abort = 0;
        a_if.out_ready = 1'b1; b_if.out_ready = 1'b1; c_if.out_ready = 1'b1;
        tick(); tick();
        chk("reset_a", {a_if.kt_valid, a_if.kt, a_if.kt_round, a_if.kt_last, a_busy, a_done}, 0);
        chk("reset_b", {b_if.kt_valid, b_if.kt, b_busy, b_done}, 0);
        reset_n = 1'b1;
        tick();

        // T1: single lane, full run
        a_start = 1; tick(); a_start = 0;
        chk("t1_first", {a_if.kt_valid, a_if.kt, a_if.kt_round}, {1'b1, 32'h428a2f98, 6'd0});
        errs = 0;
        for (int b = 0; b < 64; b++) begin
            if (!(a_if.kt_valid === 1'b1 && a_if.kt === k_ref[b] && a_if.kt_round === 6'(b) &&
                  a_if.kt_last === (b == 63) && a_done === 1'b0)) errs++;
            if (b == 63) chk("t1_last", {a_if.kt, a_if.kt_last}, {32'hc67178f2, 1'b1});
            tick();
        end
        chk("t1_seq", errs, 0);
        chk("t1_done", {a_done, a_busy, a_if.kt_valid}, 3'b100);
        tick();
        chk("t1_done_pulse", a_done, 0);

        // T2: four lanes
        b_start = 1; tick(); b_start = 0;
        chk("t2_first", {b_if.kt, b_if.kt_round},
            {32'he9b5dba5, 32'hb5c0fbcf, 32'h71374491, 32'h428a2f98, 6'd0});
        errs = 0;
        for (int b = 0; b < 16; b++) begin
            if (!(b_if.kt_valid === 1'b1 &&
                  b_if.kt === {k_ref[4*b+3], k_ref[4*b+2], k_ref[4*b+1], k_ref[4*b]} &&
                  b_if.kt_round === 6'(4*b) && b_if.kt_last === (b == 15))) errs++;
            if (b == 15) chk("t2_last", {b_if.kt, b_if.kt_round, b_if.kt_last},
                             {32'hc67178f2, 32'hbef9a3f7, 32'ha4506ceb, 32'h90befffa, 6'd60, 1'b1});
            tick();
        end
        chk("t2_seq", errs, 0);
        chk("t2_done", {b_done, b_busy}, 2'b10);

        // T3: START_ROUND=3, PIPE=3 latency and beat count
        c_start = 1; tick(); c_start = 0;
        chk("t3_lat1", c_if.kt_valid, 0);
        tick();
        chk("t3_lat2", c_if.kt_valid, 0);
        tick();
        chk("t3_first", {c_if.kt_valid, c_if.kt, c_if.kt_round}, {1'b1, 32'he9b5dba5, 6'd3});
        drain_c(3, beats, errs, dones);
        chk("t3_beats", beats, 61);
        chk("t3_seq", errs, 0);
        chk("t3_dones", dones, 1);

        // T4: backpressure on round 10
        c_start = 1; tick(); c_start = 0;
        found = 0;
        for (int cyc = 0; cyc < 40 && found == 0; cyc++) begin
            if (c_if.kt_valid === 1'b1 && c_if.kt_round === 6'd10) found = 1;
            else tick();
        end
        chk("t4_reach", found, 1);
        c_if.out_ready = 1'b0;
        errs = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (!(c_if.kt_valid === 1'b1 && c_if.kt === 32'h243185be && c_if.kt_round === 6'd10))
                errs++;
        end
        chk("t4_hold", errs, 0);
        c_if.out_ready = 1'b1;
        tick();
        chk("t4_next", {c_if.kt_valid, c_if.kt, c_if.kt_round}, {1'b1, 32'h550c7dc3, 6'd11});
        drain_c(11, beats, errs, dones);
        chk("t4_beats", beats, 53);
        chk("t4_seq", errs, 0);
        chk("t4_dones", dones, 1);

        // T5: abort at round 20, start in the abort cycle ignored
        a_start = 1; tick(); a_start = 0;
        wait_a_round(20, "t5_reach");
        a_abort = 1; a_start = 1; tick(); a_abort = 0; a_start = 0;
        chk("t5_abort", {a_if.kt_valid, a_busy, a_done}, 0);
        chk("t5_kt_hold", a_if.kt, k_ref[20]);
        tick();
        chk("t5_idle", {a_if.kt_valid, a_busy, a_done}, 0);
        a_start = 1; tick(); a_start = 0;
        chk("t5_restart", {a_if.kt_valid, a_if.kt, a_if.kt_round}, {1'b1, 32'h428a2f98, 6'd0});

        // T6: start while busy ignored; reset mid-run
        wait_a_round(30, "t6_reach30");
        a_start = 1; tick(); a_start = 0;
        chk("t6_start_ign", {a_if.kt_valid, a_if.kt_round, a_busy}, {1'b1, 6'd31, 1'b1});
        wait_a_round(40, "t6_reach40");
        reset_n = 1'b0;
        #1;
        chk("t6_reset", {a_if.kt_valid, a_if.kt, a_if.kt_round, a_if.kt_last, a_busy, a_done}, 0);
        tick();
        reset_n = 1'b1;
        tick();
        a_start = 1; tick(); a_start = 0;
        chk("t6_first", {a_if.kt_valid, a_if.kt, a_if.kt_round}, {1'b1, 32'h428a2f98, 6'd0});
        drain_a(0, beats, errs, dones);
        chk("t6_beats", beats, 64);
        chk("t6_seq", errs, 0);
        chk("t6_dones", dones, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
